// File: rtl/ldl_rr_pkg.sv
// Shared types, default widths and index helpers for the CoS round-robin arbiter.
package ldl_rr_pkg;

  localparam int unsigned DEF_BIN_WIDTH = 3;
  localparam int unsigned DEF_COS_WIDTH = 2;
  localparam int unsigned DEF_REQ_WIDTH = 1 << DEF_BIN_WIDTH;

  // onehot2bin operates on a fixed-width container; callers zero-extend and truncate.
  localparam int unsigned OH2B_IDX_WIDTH = 6;
  localparam int unsigned OH2B_WIDTH     = 1 << OH2B_IDX_WIDTH;

  typedef logic [DEF_REQ_WIDTH-1:0][DEF_COS_WIDTH-1:0] cos_vec_t;

  // OR of the indices of all set bits; exact for one-hot and all-zero inputs.
  function automatic logic [OH2B_IDX_WIDTH-1:0] onehot2bin(input logic [OH2B_WIDTH-1:0] oh);
    logic [OH2B_IDX_WIDTH-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < OH2B_WIDTH; i++) begin
      if (oh[i]) b = b | OH2B_IDX_WIDTH'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/ldl_rr_cos_arbiter_find_first.sv
// Rotating find-first-set: scans vec upward from start with wrap-around,
// returning the first set bit as one-hot and binary (zeros when vec is empty).
module ldl_rr_find_first
  import ldl_rr_pkg::*;
#(
  parameter  int unsigned IDX_WIDTH = DEF_BIN_WIDTH,
  localparam int unsigned WIDTH     = 1 << IDX_WIDTH
) (
  input  logic [WIDTH-1:0]     vec,
  input  logic [IDX_WIDTH-1:0] start,
  output logic [WIDTH-1:0]     hot,
  output logic [IDX_WIDTH-1:0] bin
);

  logic                 found;
  logic [IDX_WIDTH-1:0] idx;

  // Index arithmetic wraps naturally because WIDTH is a power of two.
  always_comb begin
    hot   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      idx = start + IDX_WIDTH'(k);
      if (!found && vec[idx]) begin
        hot[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign bin = IDX_WIDTH'(onehot2bin(OH2B_WIDTH'(hot)));

endmodule

// File: rtl/ldl_rr_cos_arbiter.sv
// Round-robin arbiter with class-of-service priority: only the highest requesting
// class competes, rotating from one past the last accepted grant.
module ldl_rr_cos_arbiter
  import ldl_rr_pkg::*;
#(
  parameter  int unsigned BIN_WIDTH = DEF_BIN_WIDTH,
  parameter  int unsigned COS_WIDTH = DEF_COS_WIDTH,
  localparam int unsigned REQ_WIDTH = 1 << BIN_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [REQ_WIDTH-1:0]                req,
  input  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] cos,
  input  logic                                ready,
  output logic [REQ_WIDTH-1:0]                hot,
  output logic [BIN_WIDTH-1:0]                bin,
  output logic                                valid
);

  logic [COS_WIDTH-1:0] maxcos;
  logic [REQ_WIDTH-1:0] eligible;
  logic [BIN_WIDTH-1:0] start_idx;
  logic [BIN_WIDTH-1:0] ptr_d, ptr_q;

  // Classes of idle requesters never influence the maximum.
  always_comb begin
    maxcos = '0;
    for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
      if (req[i] && (cos[i] > maxcos)) maxcos = cos[i];
    end
    eligible = '0;
    for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
      eligible[i] = req[i] && (cos[i] == maxcos);
    end
  end

  assign start_idx = ptr_q + BIN_WIDTH'(1);

  ldl_rr_find_first #(
    .IDX_WIDTH (BIN_WIDTH)
  ) u_find_first (
    .vec   (eligible),
    .start (start_idx),
    .hot   (hot),
    .bin   (bin)
  );

  assign valid = |req;

  always_comb begin
    ptr_d = ptr_q;
    if (valid && ready) ptr_d = bin;
  end

  // Reset to the last index so the first search begins at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '1;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: tb/tb_ldl_rr_cos_arbiter.sv
// Directed scoreboard bench for ldl_rr_cos_arbiter (BIN_WIDTH=3, COS_WIDTH=2).
module tb_ldl_rr_cos_arbiter;
  import ldl_rr_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  cos_vec_t   cos;
  logic       ready;
  logic [7:0] hot;
  logic [2:0] bin;
  logic       valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] hot;
    logic [2:0] bin;
    logic       valid;
    logic [2:0] ptr;
  } exp_t;

  exp_t sb[$];

  ldl_rr_cos_arbiter #(
    .BIN_WIDTH (3),
    .COS_WIDTH (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .cos   (cos),
    .ready (ready),
    .hot   (hot),
    .bin   (bin),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the expected response.
  task automatic step(input string nm, input logic r, input logic [7:0] rq, input cos_vec_t cv,
                      input logic rdy, input logic ev, input logic [2:0] eb, input logic [2:0] ep);
    exp_t e;
    @(posedge clk);
    #1;
    rst   = r;
    req   = rq;
    cos   = cv;
    ready = rdy;
    e.name  = nm;
    e.valid = ev;
    e.bin   = eb;
    e.ptr   = ep;
    e.hot   = ev ? (8'h01 << eb) : 8'h00;
    sb.push_back(e);
  endtask

  // Monitor: compares every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (valid !== e.valid) begin
          errors++;
          $display("FAIL %s valid: got %b expected %b", e.name, valid, e.valid);
        end
        checks++;
        if (hot !== e.hot) begin
          errors++;
          $display("FAIL %s hot: got %h expected %h", e.name, hot, e.hot);
        end
        checks++;
        if (bin !== e.bin) begin
          errors++;
          $display("FAIL %s bin: got %0d expected %0d", e.name, bin, e.bin);
        end
        checks++;
        if (dut.ptr_q !== e.ptr) begin
          errors++;
          $display("FAIL %s ptr: got %0d expected %0d", e.name, dut.ptr_q, e.ptr);
        end
      end
    end
  end

  initial begin
    int w;
    rst   = 1'b1;
    req   = 8'h00;
    cos   = '0;
    ready = 1'b0;

    // Reset state, no requests
    step("rst_idle",  1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd7);

    // Plain round-robin over A5 with equal classes
    step("rr_a5_0",   1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd0, 3'd7);
    step("rr_a5_1",   1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd2, 3'd0);
    step("rr_a5_2",   1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd5, 3'd2);
    step("rr_a5_3",   1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd7, 3'd5);
    step("rr_a5_4",   1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd0, 3'd7);
    step("rr_a5_5",   1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd2, 3'd0);
    step("rr_a5_6",   1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd5, 3'd2);
    step("rr_a5_7",   1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd7, 3'd5);

    // cos {3,2,1,0,3,2,1,0}: only 3 and 7 compete
    step("cos3_rst",  1'b1, 8'hFF, 16'hE4E4, 1'b1, 1'b1, 3'd3, 3'd7);
    step("cos3_0",    1'b0, 8'hFF, 16'hE4E4, 1'b1, 1'b1, 3'd3, 3'd7);
    step("cos3_1",    1'b0, 8'hFF, 16'hE4E4, 1'b1, 1'b1, 3'd7, 3'd3);
    step("cos3_2",    1'b0, 8'hFF, 16'hE4E4, 1'b1, 1'b1, 3'd3, 3'd7);
    step("cos3_3",    1'b0, 8'hFF, 16'hE4E4, 1'b1, 1'b1, 3'd7, 3'd3);

    // cos {0,2,1,0,0,2,1,0}: 2 and 6 compete
    step("cos2_rst",  1'b1, 8'hFF, 16'h2424, 1'b1, 1'b1, 3'd2, 3'd7);
    step("cos2_0",    1'b0, 8'hFF, 16'h2424, 1'b1, 1'b1, 3'd2, 3'd7);
    step("cos2_1",    1'b0, 8'hFF, 16'h2424, 1'b1, 1'b1, 3'd6, 3'd2);
    step("cos2_2",    1'b0, 8'hFF, 16'h2424, 1'b1, 1'b1, 3'd2, 3'd6);

    // cos {0,0,1,0,0,0,1,0}: 1 and 5 compete
    step("cos1_rst",  1'b1, 8'hFF, 16'h0404, 1'b1, 1'b1, 3'd1, 3'd7);
    step("cos1_0",    1'b0, 8'hFF, 16'h0404, 1'b1, 1'b1, 3'd1, 3'd7);
    step("cos1_1",    1'b0, 8'hFF, 16'h0404, 1'b1, 1'b1, 3'd5, 3'd1);
    step("cos1_2",    1'b0, 8'hFF, 16'h0404, 1'b1, 1'b1, 3'd1, 3'd5);

    // Backpressure: grant 2 held while ready is low
    step("bp_rst",    1'b1, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd0, 3'd7);
    step("bp_acc0",   1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd0, 3'd7);
    step("bp_hold0",  1'b0, 8'hA5, 16'h0000, 1'b0, 1'b1, 3'd2, 3'd0);
    step("bp_hold1",  1'b0, 8'hA5, 16'h0000, 1'b0, 1'b1, 3'd2, 3'd0);
    step("bp_hold2",  1'b0, 8'hA5, 16'h0000, 1'b0, 1'b1, 3'd2, 3'd0);
    step("bp_acc2",   1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd2, 3'd0);
    step("bp_next5",  1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd5, 3'd2);

    // No requests: outputs idle, pointer holds; then a single requester
    step("idle_0",    1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 3'd0, 3'd5);
    step("idle_1",    1'b0, 8'h00, 16'hFFFF, 1'b1, 1'b0, 3'd0, 3'd5);
    step("single_0",  1'b0, 8'h80, 16'h0000, 1'b1, 1'b1, 3'd7, 3'd5);
    step("single_1",  1'b0, 8'h80, 16'h0000, 1'b1, 1'b1, 3'd7, 3'd7);
    step("single_ign",1'b0, 8'h80, 16'h3FFF, 1'b1, 1'b1, 3'd7, 3'd7);

    // Async reset mid-sequence after grant 5 accepted
    step("ar_0",      1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd0, 3'd7);
    step("ar_2",      1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd2, 3'd0);
    step("ar_5",      1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd5, 3'd2);
    step("ar_pre",    1'b0, 8'hA5, 16'h0000, 1'b0, 1'b1, 3'd7, 3'd5);
    step("ar_assert", 1'b1, 8'hA5, 16'h0000, 1'b0, 1'b1, 3'd0, 3'd7);
    step("ar_held",   1'b1, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd0, 3'd7);
    step("ar_rel0",   1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd0, 3'd7);
    step("ar_rel2",   1'b0, 8'hA5, 16'h0000, 1'b1, 1'b1, 3'd2, 3'd0);

    w = 0;
    while (sb.size() != 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
